// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: streams bitstream words, LSB first, into a serial chain
// of configuration flip-flops. Counts the ones returned on ccff_tail while
// shifting.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 48,
  parameter int WORD_W    = 8,
  localparam int CNT_W    = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              ccff_tail,
  output logic              ccff_head,
  output logic              config_enable,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  tail_ones
);

  // Width of the bit index within one word. A one-bit word still gets a
  // one-bit index so the arithmetic below stays uniform.
  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [BIT_W-1:0] LAST_WBIT      = BIT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] LAST_CHAIN_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CHAIN_MAX      = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);
  localparam logic [BIT_W-1:0] WBIT_ONE       = BIT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  sreg_q, sreg_d;        // remaining bits of the current word
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;  // bits shifted into the chain so far
  logic [BIT_W-1:0]   wbit_q, wbit_d;        // index of the bit now on ccff_head
  logic [CNT_W-1:0]   tail_ones_q, tail_ones_d;
  logic               ccff_head_q, ccff_head_d;
  logic               config_enable_q, config_enable_d;
  logic               aborted_q, aborted_d;

  // Last bit of the current word: either the word is used up, or the chain
  // is full (the truncated final word when CHAIN_LEN is not a multiple of
  // WORD_W -- its upper bits are simply never driven).
  logic word_last;
  logic chain_last;

  assign chain_last = (bit_cnt_q == LAST_CHAIN_BIT);
  assign word_last  = (wbit_q == LAST_WBIT) || chain_last;

  // State register and all datapath flops; pReset clears everything at once
  // so config_enable drops in the same cycle the reset arrives.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q         <= IDLE;
      sreg_q          <= '0;
      bit_cnt_q       <= '0;
      wbit_q          <= '0;
      tail_ones_q     <= '0;
      ccff_head_q     <= 1'b0;
      config_enable_q <= 1'b0;
      aborted_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      sreg_q          <= sreg_d;
      bit_cnt_q       <= bit_cnt_d;
      wbit_q          <= wbit_d;
      tail_ones_q     <= tail_ones_d;
      ccff_head_q     <= ccff_head_d;
      config_enable_q <= config_enable_d;
      aborted_q       <= aborted_d;
    end
  end

  // Next-state and next-output logic. ccff_head/config_enable are computed
  // one cycle ahead so that their registered values line up with the SHIFT
  // cycles: every cycle spent in SHIFT shows one valid bit with enable high.
  always_comb begin
    state_d         = state_q;
    sreg_d          = sreg_q;
    bit_cnt_d       = bit_cnt_q;
    wbit_d          = wbit_q;
    tail_ones_d     = tail_ones_q;
    ccff_head_d     = 1'b0;
    config_enable_d = 1'b0;
    aborted_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          bit_cnt_d   = '0;
          tail_ones_d = '0;
          wbit_d      = '0;
          state_d     = LOAD;
        end
      end

      LOAD: begin
        if (abort) begin
          // Abort wins over a word offered in the same cycle.
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (in_valid) begin
          ccff_head_d     = in_data[0];
          config_enable_d = 1'b1;
          sreg_d          = in_data >> 1;
          wbit_d          = '0;
          state_d         = SHIFT;
        end
      end

      SHIFT: begin
        // The bit on ccff_head is clocked into the chain at the end of this
        // cycle, even if abort is raised now, so it is counted and the tail
        // sample taken in the same cycle is accumulated as well.
        if (bit_cnt_q != CHAIN_MAX) begin
          bit_cnt_d = bit_cnt_q + CNT_ONE;
        end
        if (ccff_tail && (tail_ones_q != CHAIN_MAX)) begin
          tail_ones_d = tail_ones_q + CNT_ONE;
        end

        if (abort) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (word_last) begin
          // Drop enable for at least one bubble cycle before the next word.
          state_d = chain_last ? DONE : LOAD;
        end else begin
          ccff_head_d     = sreg_q[0];
          config_enable_d = 1'b1;
          sreg_d          = sreg_q >> 1;
          wbit_d          = wbit_q + WBIT_ONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready      = (state_q == LOAD);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign aborted       = aborted_q;
  assign ccff_head     = ccff_head_q;
  assign config_enable = config_enable_q;
  assign tail_ones     = tail_ones_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: a 48-bit and a 20-bit instance, each
// followed by a behavioural model of the downstream chain.
module tb_ccff_chain_loader;

  logic prog_clk = 1'b0;
  logic pReset   = 1'b1;

  always #5 prog_clk = ~prog_clk;

  // Shared stimulus, steered to one instance by dut_sel (0: A, 1: B)
  logic       dut_sel  = 1'b0;
  logic       start_x  = 1'b0;
  logic       abort_x  = 1'b0;
  logic       valid_x  = 1'b0;
  logic [7:0] in_data_x = 8'h00;

  // Instance A: CHAIN_LEN=48
  logic       start_a, abort_a, in_valid_a, in_ready_a, ccff_tail_a;
  logic       ccff_head_a, config_enable_a, busy_a, done_a, aborted_a;
  logic [5:0] tail_ones_a;
  // Instance B: CHAIN_LEN=20
  logic       start_b, abort_b, in_valid_b, in_ready_b, ccff_tail_b;
  logic       ccff_head_b, config_enable_b, busy_b, done_b, aborted_b;
  logic [4:0] tail_ones_b;

  assign start_a    = start_x & ~dut_sel;
  assign abort_a    = abort_x & ~dut_sel;
  assign in_valid_a = valid_x & ~dut_sel;
  assign start_b    = start_x &  dut_sel;
  assign abort_b    = abort_x &  dut_sel;
  assign in_valid_b = valid_x &  dut_sel;

  ccff_chain_loader #(.CHAIN_LEN(48), .WORD_W(8)) u_dut_a (
    .prog_clk(prog_clk), .pReset(pReset), .start(start_a), .abort(abort_a),
    .in_data(in_data_x), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .ccff_tail(ccff_tail_a), .ccff_head(ccff_head_a),
    .config_enable(config_enable_a), .busy(busy_a), .done(done_a),
    .aborted(aborted_a), .tail_ones(tail_ones_a)
  );

  ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) u_dut_b (
    .prog_clk(prog_clk), .pReset(pReset), .start(start_b), .abort(abort_b),
    .in_data(in_data_x), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .ccff_tail(ccff_tail_b), .ccff_head(ccff_head_b),
    .config_enable(config_enable_b), .busy(busy_b), .done(done_b),
    .aborted(aborted_b), .tail_ones(tail_ones_b)
  );

  // Muxed view of the selected instance
  logic cfg_en_m, head_m, ready_m, busy_m, done_m, aborted_m;
  assign cfg_en_m  = dut_sel ? config_enable_b : config_enable_a;
  assign head_m    = dut_sel ? ccff_head_b     : ccff_head_a;
  assign ready_m   = dut_sel ? in_ready_b      : in_ready_a;
  assign busy_m    = dut_sel ? busy_b          : busy_a;
  assign done_m    = dut_sel ? done_b          : done_a;
  assign aborted_m = dut_sel ? aborted_b       : aborted_a;

  // Downstream chain models: enable/head captured mid-cycle, shifted on the
  // following rising edge, so the tail seen by the DUT is the pre-shift bit.
  logic [47:0] chain_a = '0;
  logic [19:0] chain_b = '0;
  logic        en_sa = 1'b0, head_sa = 1'b0, en_sb = 1'b0, head_sb = 1'b0;
  logic        preload_a = 1'b0;

  assign ccff_tail_a = chain_a[47];
  assign ccff_tail_b = chain_b[19];

  always @(negedge prog_clk) begin
    en_sa   <= config_enable_a;
    head_sa <= ccff_head_a;
    en_sb   <= config_enable_b;
    head_sb <= ccff_head_b;
  end

  always @(posedge prog_clk) begin
    if (preload_a)  chain_a <= '1;
    else if (en_sa) chain_a <= {chain_a[46:0], head_sa};
    if (en_sb)      chain_b <= {chain_b[18:0], head_sb};
  end

  // Bookkeeping
  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  words [8];
  logic [63:0] rec;
  int          en_cnt, done_cnt, ab_cnt, done_cyc, idle_cyc, overlap_cnt;
  bit          timed_out;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else begin
      n_pass++;
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Expected head stream: word i/8, bit i%8, LSB first, first nbits only
  function automatic logic [63:0] exp_stream(input int nbits);
    logic [63:0] s;
    logic [7:0]  w;
    s = '0;
    for (int i = 0; i < nbits; i++) begin
      w    = words[i / 8];
      s[i] = w[i % 8];
    end
    return s;
  endfunction

  task automatic fill_words(input logic [7:0] w);
    for (int i = 0; i < 8; i++) words[i] = w;
  endtask

  task automatic check_quiet_a(input string tag);
    check_eq(tag, {57'd0, ccff_head_a, config_enable_a, in_ready_a, busy_a,
                   done_a, aborted_a, 1'b0} | {58'd0, tail_ones_a}, 64'd0);
  endtask

  task automatic do_preload_a();
    @(negedge prog_clk) preload_a = 1'b1;
    @(negedge prog_clk) preload_a = 1'b0;
  endtask

  // One load on the selected instance. All observation and driving happens
  // on the falling edge. Optional events are keyed to the shift-cycle count:
  // abort_at / rst_at / start_at (0 = none).
  task automatic run_load(input bit sel, input int nw, input bit hold,
                          input int gap_after, input int gap_len,
                          input int abort_at, input int rst_at, input int start_at);
    int widx;
    int gap_done;
    widx = 0; gap_done = 0;
    en_cnt = 0; done_cnt = 0; ab_cnt = 0; done_cyc = -10; idle_cyc = -1;
    overlap_cnt = 0; rec = '0; timed_out = 1'b1;
    @(negedge prog_clk);
    dut_sel = sel;
    start_x = 1'b1;
    valid_x = 1'b0;
    @(negedge prog_clk);
    start_x = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cfg_en_m) begin
        if (en_cnt < 64) rec[en_cnt] = head_m;
        en_cnt++;
      end
      if (cfg_en_m && ready_m) overlap_cnt++;
      if (done_m) begin done_cnt++; done_cyc = cyc; end
      if (aborted_m) ab_cnt++;
      if (!busy_m) begin idle_cyc = cyc; timed_out = 1'b0; break; end

      abort_x = (abort_at > 0) && cfg_en_m && (en_cnt == abort_at);
      start_x = (start_at > 0) && cfg_en_m && (en_cnt == start_at);
      if ((rst_at > 0) && cfg_en_m && (en_cnt == rst_at)) begin
        pReset = 1'b1;
        #1;
        check_quiet_a("reset_mid_shift_outputs");
        @(negedge prog_clk);
        check_quiet_a("reset_held_outputs");
        pReset = 1'b0;
        timed_out = 1'b0;
        break;
      end
      if (ready_m) begin
        if ((widx == gap_after) && (gap_done < gap_len)) begin
          valid_x = 1'b0;
          gap_done++;
        end else if (widx < nw) begin
          valid_x   = 1'b1;
          in_data_x = words[widx];
          widx++;
        end else begin
          valid_x = 1'b0;
        end
      end else begin
        valid_x = hold;
      end
      @(negedge prog_clk);
    end
    abort_x = 1'b0;
    start_x = 1'b0;
    valid_x = 1'b0;
    check_eq("load_timeout", {63'd0, timed_out}, 64'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge prog_clk);
    check_quiet_a("reset_state");
    pReset = 1'b0;
    @(negedge prog_clk);

    // Six 0xA5 words, in_valid held high
    fill_words(8'hA5);
    run_load(1'b0, 6, 1'b1, 99, 0, 0, 0, 0);
    check_eq("a5_enable_cycles", en_cnt, 48);
    check_eq("a5_head_stream", rec, exp_stream(48));
    check_eq("a5_done_pulses", done_cnt, 1);
    check_eq("a5_busy_after_done", idle_cyc, done_cyc + 1);
    check_eq("a5_no_abort", ab_cnt, 0);
    check_eq("a5_tail_ones", tail_ones_a, 0);

    // Chain full of ones, load zeros: every returned bit is a one
    do_preload_a();
    fill_words(8'h00);
    run_load(1'b0, 6, 1'b0, 99, 0, 0, 0, 0);
    check_eq("ones_tail_ones", tail_ones_a, 48);
    check_eq("ones_enable_cycles", en_cnt, 48);
    run_load(1'b0, 6, 1'b0, 99, 0, 0, 0, 0);
    check_eq("zeros_tail_ones", tail_ones_a, 0);

    // Abort on the 10th shift cycle, chain full of ones
    do_preload_a();
    run_load(1'b0, 6, 1'b0, 99, 0, 10, 0, 0);
    check_eq("abort_enable_cycles", en_cnt, 10);
    check_eq("abort_pulse", ab_cnt, 1);
    check_eq("abort_no_done", done_cnt, 0);
    check_eq("abort_cfg_en_low", config_enable_a, 0);
    check_eq("abort_tail_ones", tail_ones_a, 10);
    @(negedge prog_clk);
    check_eq("abort_pulse_single", aborted_a, 0);
    check_eq("abort_tail_held", tail_ones_a, 10);

    // Abort in IDLE is ignored; abort beats in_valid in LOAD
    dut_sel = 1'b0; start_x = 1'b1; abort_x = 1'b1;
    @(negedge prog_clk);
    start_x = 1'b0; abort_x = 1'b0;
    check_eq("idle_abort_ignored", {in_ready_a, aborted_a}, 2'b10);
    valid_x = 1'b1; in_data_x = 8'hFF; abort_x = 1'b1;
    @(negedge prog_clk);
    valid_x = 1'b0; abort_x = 1'b0;
    check_eq("load_abort_priority", {busy_a, aborted_a, config_enable_a}, 3'b010);

    // Gap of 5 cycles between words 2 and 3
    words[0] = 8'h3C; words[1] = 8'h81; words[2] = 8'h5A;
    words[3] = 8'hE7; words[4] = 8'h19; words[5] = 8'h42;
    run_load(1'b0, 6, 1'b0, 2, 5, 0, 0, 0);
    check_eq("gap_head_stream", rec, exp_stream(48));
    check_eq("gap_enable_cycles", en_cnt, 48);
    check_eq("gap_no_enable_in_load", overlap_cnt, 0);
    check_eq("gap_done_pulses", done_cnt, 1);

    // Reset in SHIFT, then a load with a start pulse while busy
    fill_words(8'hA5);
    run_load(1'b0, 6, 1'b0, 99, 0, 0, 5, 0);
    repeat (3) @(negedge prog_clk);
    check_eq("no_resume_after_reset", {busy_a, config_enable_a}, 2'b00);
    fill_words(8'h96);
    run_load(1'b0, 6, 1'b0, 99, 0, 0, 0, 20);
    check_eq("restart_enable_cycles", en_cnt, 48);
    check_eq("restart_head_stream", rec, exp_stream(48));
    check_eq("restart_done_pulses", done_cnt, 1);

    // CHAIN_LEN=20: truncated final word
    fill_words(8'h00);
    words[0] = 8'hFF; words[1] = 8'hFF; words[2] = 8'h0F;
    run_load(1'b1, 3, 1'b0, 99, 0, 0, 0, 0);
    check_eq("len20_enable_cycles", en_cnt, 20);
    check_eq("len20_head_stream", rec, 64'h00000000000FFFFF);
    check_eq("len20_done_pulses", done_cnt, 1);
    words[2] = 8'hF3;
    run_load(1'b1, 3, 1'b0, 99, 0, 0, 0, 0);
    check_eq("len20_upper_nibble_dropped", rec, 64'h000000000003FFFF);
    check_eq("len20_enable_cycles_f3", en_cnt, 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
